// File: rtl/cfg_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_loader_if
//  Brief    : Byte-wide valid/ready configuration stream between the
//             bitstream source (master) and the configuration loader (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface cfg_loader_if;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_ready_o;

  // Bitstream source side
  modport master (
    output s_data_i,
    output s_valid_i,
    input  s_ready_o
  );

  // Loader side
  modport slave (
    input  s_data_i,
    input  s_valid_i,
    output s_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_loader
//  Brief    : Configuration controller for an array of N_CLB CLBs. Assembles
//             23-bit words from byte triplets, writes each word to the next
//             CLB with a one-hot single-cycle strobe, then verifies a trailing
//             XOR checksum byte.
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_loader #(
  parameter int N_CLB = 4,
  parameter int CFG_W = 23   // word is carried in 3 bytes; MSB of byte 0 dropped
) (
  input  wire logic               clk_i,
  input  wire logic               rst_ni,
  input  wire logic               start_i,
  input  wire logic               abort_i,
  cfg_loader_if.slave             s_if,
  output logic [CFG_W-1:0]        cfg_bits_o,
  output logic [N_CLB-1:0]        cfg_wr_en_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int                 c_IDX_W    = (N_CLB > 1) ? $clog2(N_CLB) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_CLB - 1);
  localparam logic [1:0]         c_LAST_BYTE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [1:0]           r_byte_cnt;
  logic [c_IDX_W-1:0]   r_clb_idx;
  // Only the last two bytes are kept; bit 7 of the first byte of a word
  // falls off the top because it never reaches the 23-bit word.
  logic [14:0]          r_asm;
  logic [7:0]           r_xor;
  logic [CFG_W-1:0]     r_cfg_bits;

  logic                 w_ready;
  logic                 w_xfer;
  logic                 w_start;
  logic                 w_last_clb;

  // Ready depends on state only, keeping the handshake free of comb loops.
  assign w_ready    = (r_state == S_RECV) || (r_state == S_CHECK);
  assign w_xfer     = s_if.s_valid_i && w_ready;
  assign w_last_clb = (r_clb_idx == c_LAST_IDX);

  assign s_if.s_ready_o = w_ready;
  assign cfg_bits_o     = r_cfg_bits;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode; abort outranks any same-cycle transfer
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        done_o = (r_state == S_DONE);
        err_o  = (r_state == S_ERR);
        if (start_i) begin
          w_state_nxt = S_RECV;
          w_start     = 1'b1;
        end
      end
      S_RECV: begin
        busy_o = 1'b1;
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer && (r_byte_cnt == c_LAST_BYTE)) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        busy_o = 1'b1;
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_last_clb) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_state_nxt = S_RECV;
        end
      end
      S_CHECK: begin
        busy_o = 1'b1;
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer) begin
          w_state_nxt = (s_if.s_data_i == r_xor) ? S_DONE : S_ERR;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Word assembly, checksum accumulation and CLB index tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_cnt <= 2'd0;
      r_clb_idx  <= '0;
      r_asm      <= '0;
      r_xor      <= 8'd0;
      r_cfg_bits <= '0;
    end else if (w_start) begin
      r_byte_cnt <= 2'd0;
      r_clb_idx  <= '0;
      r_xor      <= 8'd0;
    end else if ((r_state == S_RECV) && w_xfer && !abort_i) begin
      r_asm <= {r_asm[6:0], s_if.s_data_i};
      r_xor <= r_xor ^ s_if.s_data_i;
      if (r_byte_cnt == c_LAST_BYTE) begin
        r_byte_cnt <= 2'd0;
        r_cfg_bits <= CFG_W'({r_asm, s_if.s_data_i});
      end else begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
    end else if ((r_state == S_WRITE) && !abort_i && !w_last_clb) begin
      r_clb_idx <= r_clb_idx + c_IDX_W'(1);
    end
  end

  // One-hot write strobe, only ever active in WRITE
  for (genvar k = 0; k < N_CLB; k++) begin : g_wr_en
    assign cfg_wr_en_o[k] = (r_state == S_WRITE) && (r_clb_idx == c_IDX_W'(k));
  end

endmodule
`default_nettype wire
